// File: rtl/fp8_add_sched.sv
// Round-robin scheduler that shares one FP8 adder among N_REQ requesters, with a
// registered operand stage (S1) and a registered response stage (S2) under backpressure.

// Combinational FP8 adder. FP8_TYPE 0 is E4M3 and 1 is E5M2, both IEEE-like: the all-ones
// exponent encodes inf/NaN, subnormals are supported, rounding is to nearest even.
module adderFP8 #(
    parameter int FP8_TYPE = 0
) (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] C
);
    localparam int EW   = (FP8_TYPE == 0) ? 4 : 5;
    localparam int MW   = 7 - EW;
    localparam int EMAX = (1 << EW) - 1;
    // Wide enough to hold any finite operand exactly in units of the smallest subnormal.
    localparam int SW   = 34;

    function automatic logic [SW-1:0] to_fixed(input logic [7:0] x);
        logic [EW-1:0] ex;
        logic [MW:0]   sig;
        int            sh;
        ex  = x[6:MW];
        sig = {(ex != '0), x[MW-1:0]};
        sh  = (ex == '0) ? 0 : int'(ex) - 1;
        return SW'(sig) << sh;
    endfunction

    logic          a_nan, b_nan, a_inf, b_inf, neg, up;
    logic [SW-1:0] fa, fb, sum, mag, keep, rem, half;
    int            p, shift, e;

    assign a_nan = (A[6:MW] == {EW{1'b1}}) && (A[MW-1:0] != '0);
    assign b_nan = (B[6:MW] == {EW{1'b1}}) && (B[MW-1:0] != '0);
    assign a_inf = (A[6:MW] == {EW{1'b1}}) && (A[MW-1:0] == '0);
    assign b_inf = (B[6:MW] == {EW{1'b1}}) && (B[MW-1:0] == '0);

    always_comb begin
        fa  = to_fixed(A);
        fb  = to_fixed(B);
        sum = (A[7] ? -fa : fa) + (B[7] ? -fb : fb);
        neg = sum[SW-1];
        mag = neg ? -sum : sum;
        p   = 0;
        for (int i = 0; i < SW; i++) begin
            if (mag[i]) p = i;
        end
        shift = (p > MW) ? p - MW : 0;
        keep  = mag >> shift;
        rem   = mag & ~({SW{1'b1}} << shift);
        half  = (shift > 0) ? (SW'(1) << (shift - 1)) : '0;
        up    = (shift > 0) && ((rem > half) || ((rem == half) && keep[0]));
        keep  = keep + SW'(up);
        e     = p - MW + 1;
        // Rounding carried out of the significand: renormalise.
        if (keep[MW+1]) begin
            e    = e + 1;
            keep = keep >> 1;
        end
        if (a_nan || b_nan || (a_inf && b_inf && (A[7] != B[7]))) C = 8'h7F;
        else if (a_inf)       C = A;
        else if (b_inf)       C = B;
        else if (mag == '0)   C = {A[7] & B[7], 7'd0};
        else if (p < MW)      C = {neg, {EW{1'b0}}, mag[MW-1:0]};
        else if (e >= EMAX)   C = {neg, {EW{1'b1}}, {MW{1'b0}}};
        else                  C = {neg, e[EW-1:0], keep[MW-1:0]};
    end
endmodule

module fp8_add_sched #(
    parameter int N_REQ    = 4,
    parameter int FP8_TYPE = 0,
    parameter int ID_W     = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    output logic [7:0]           rsp_c,
    output logic [ID_W-1:0]      rsp_id,
    input  logic                 rsp_ready,
    output logic                 busy,
    output logic [15:0]          op_count
);
    logic            s1_valid_q, s1_valid_d;
    logic [7:0]      s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_c_q, rsp_c_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]     op_count_q, op_count_d;

    logic            s1_en, s2_en, grant_any, accept;
    logic [ID_W-1:0] grant_id;
    logic [7:0]      adder_c;

    adderFP8 #(.FP8_TYPE(FP8_TYPE)) u_adder (
        .A (s1_a_q),
        .B (s1_b_q),
        .C (adder_c)
    );

    assign s2_en = !rsp_valid_q || rsp_ready;
    assign s1_en = !s1_valid_q || s2_en;

    always_comb begin : arb
        int idx;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx[ID_W-1:0];
            end
        end
    end

    // Grants are masked during reset so nothing is accepted on the reset edge.
    assign accept = grant_any && s1_en && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_id] = 1'b1;
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_c_d     = rsp_c_q;
        rsp_id_d    = rsp_id_q;
        rr_ptr_d    = rr_ptr_q;
        op_count_d  = op_count_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = req_a[8*grant_id +: 8];
            s1_b_d     = req_b[8*grant_id +: 8];
            s1_id_d    = grant_id;
            rr_ptr_d   = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            op_count_d = op_count_q + 16'd1;
        end else if (s1_en) begin
            s1_valid_d = 1'b0;
        end
        if (s2_en) begin
            rsp_valid_d = s1_valid_q;
            rsp_c_d     = adder_c;
            rsp_id_d    = s1_id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_c_q     <= '0;
            rsp_id_q    <= '0;
            rr_ptr_q    <= '0;
            op_count_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_c_q     <= rsp_c_d;
            rsp_id_q    <= rsp_id_d;
            rr_ptr_q    <= rr_ptr_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = s1_valid_q || rsp_valid_q;
    assign op_count  = op_count_q;
endmodule

// File: tb/tb_fp8_add_sched.sv
// Randomised bench for fp8_add_sched: a transaction-level scoreboard plus a real-number
// E4M3 reference adder predict every handshake, response and counter value.
module tb_fp8_add_sched;
    localparam int N    = 4;
    localparam int BIAS = 7;
    localparam int MW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [8*N-1:0] req_a, req_b;
    logic [N-1:0]  req_ready;
    logic          rsp_valid, rsp_ready, busy;
    logic [7:0]    rsp_c;
    logic [1:0]    rsp_id;
    logic [15:0]   op_count;

    always #5 clk = ~clk;

    fp8_add_sched #(.N_REQ(N), .FP8_TYPE(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_c     (rsp_c),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .op_count  (op_count)
    );

    typedef struct {
        int         id;
        logic [7:0] c;
        int         cyc;
    } item_t;

    item_t q[$];
    int    m_ptr = 0, m_cnt = 0, edge_no = 0;
    int    n_checks = 0, n_errors = 0;
    logic  last_acc;
    int    last_acc_id;
    logic  obs_rsp_valid;
    logic [7:0] obs_rsp_c;
    logic [1:0] obs_rsp_id;
    logic [N-1:0] obs_req_ready;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else repeat (-n) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp8_val(input logic [7:0] x);
        int  e, m;
        real v;
        e = int'(x[6:3]);
        m = int'(x[2:0]);
        if (e == 0) v = m * pow2(1 - BIAS - MW);
        else        v = (8 + m) * pow2(e - BIAS - MW);
        return x[7] ? -v : v;
    endfunction

    // Exact real sum, then nearest representable E4M3 value (ties to even code).
    function automatic logic [7:0] ref_add(input logic [7:0] a, input logic [7:0] b);
        logic a_nan, b_nan, a_inf, b_inf, sg;
        real  s, mag, d, bestd;
        logic [7:0] kc, best;
        a_nan = (a[6:3] == 4'hF) && (a[2:0] != 0);
        b_nan = (b[6:3] == 4'hF) && (b[2:0] != 0);
        a_inf = (a[6:3] == 4'hF) && (a[2:0] == 0);
        b_inf = (b[6:3] == 4'hF) && (b[2:0] == 0);
        if (a_nan || b_nan || (a_inf && b_inf && a[7] != b[7])) return 8'h7F;
        if (a_inf) return a;
        if (b_inf) return b;
        s = fp8_val(a) + fp8_val(b);
        if (s == 0.0) return {a[7] & b[7], 7'd0};
        sg  = (s < 0.0);
        mag = sg ? -s : s;
        if (mag >= fp8_val(8'h77) + pow2(14 - BIAS - MW - 1)) return {sg, 7'h78};
        best  = 8'h00;
        bestd = mag;
        for (int k = 1; k < 120; k++) begin
            kc = 8'(k);
            d  = fp8_val(kc) - mag;
            if (d < 0.0) d = -d;
            if (d < bestd || (d == bestd && kc[0] == 1'b0)) begin
                bestd = d;
                best  = kc;
            end
        end
        return {sg, best[6:0]};
    endfunction

    // One clock: check DUT against the model at the negedge, advance the model at the posedge.
    task automatic tick();
        int   g;
        logic allowed, vis;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        allowed   = !rst && !(q.size() == 2 && !rsp_ready);
        exp_ready = (allowed && g >= 0) ? N'(1 << g) : '0;
        vis       = (q.size() > 0) && (edge_no > q[0].cyc + 1);
        obs_rsp_valid = rsp_valid;
        obs_rsp_c     = rsp_c;
        obs_rsp_id    = rsp_id;
        obs_req_ready = req_ready;
        check_eq("req_ready", req_ready, exp_ready);
        if (!rst) begin
            check_eq("rsp_valid", rsp_valid, vis);
            if (vis) begin
                check_eq("rsp_c", rsp_c, q[0].c);
                check_eq("rsp_id", rsp_id, q[0].id);
            end
            check_eq("busy", busy, q.size() > 0);
            check_eq("op_count", op_count, m_cnt);
        end
        last_acc    = allowed && g >= 0;
        last_acc_id = g;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_ptr = 0;
            m_cnt = 0;
        end else begin
            if (vis && rsp_ready) void'(q.pop_front());
            if (last_acc) begin
                item_t it;
                it.id  = g;
                it.c   = ref_add(req_a[8*g +: 8], req_b[8*g +: 8]);
                it.cyc = edge_no;
                q.push_back(it);
                m_ptr = (g + 1) % N;
                m_cnt = (m_cnt + 1) & 16'hFFFF;
            end
        end
        edge_no++;
        #1;
    endtask

    task automatic new_data(input int i);
        req_a[8*i +: 8] = 8'($urandom);
        req_b[8*i +: 8] = 8'($urandom);
    endtask

    initial begin
        int ids[$];
        int dut_acc, mdl_acc, done, cyc, cnt0;
        logic [7:0] held_c;
        logic [1:0] held_id;

        // Reset with all requesters valid.
        rst = 1'b1; rsp_ready = 1'b1; req_valid = '1;
        for (int i = 0; i < N; i++) new_data(i);
        repeat (2) begin
            tick();
            check_eq("rst_rsp_valid", rsp_valid, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_op_count", op_count, 0);
        end
        rst = 1'b0;

        // Round robin from pointer 0.
        for (int c = 0; c < 10; c++) begin
            if (c == 8) req_valid = '0;
            tick();
            if (c == 0) check_eq("first_grant", obs_req_ready, 4'b0001);
            if (obs_rsp_valid) ids.push_back(int'(obs_rsp_id));
            if (last_acc) new_data(last_acc_id);
        end
        check_eq("rr_count", ids.size(), 8);
        foreach (ids[i]) check_eq("rr_seq", ids[i], i % 4);
        check_eq("rr_op_count", op_count, 8);

        // Single operation from requester 2.
        req_valid = 4'b0100;
        req_a[23:16] = 8'h38; req_b[23:16] = 8'h30;
        tick();
        check_eq("single_acc", obs_req_ready, 4'b0100);
        req_valid = '0;
        tick();
        check_eq("single_lat", obs_rsp_valid, 0);
        tick();
        check_eq("single_valid", obs_rsp_valid, 1);
        check_eq("single_c", obs_rsp_c, 8'h3C);
        check_eq("single_c_ref", obs_rsp_c, ref_add(8'h38, 8'h30));
        check_eq("single_id", obs_rsp_id, 2);
        check_eq("single_cnt", op_count, 9);

        // Backpressure on a stream from requester 1.
        req_valid = 4'b0010; new_data(1);
        repeat (4) begin
            tick();
            if (last_acc) new_data(1);
        end
        rsp_ready = 1'b0; dut_acc = 0; mdl_acc = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) begin
                held_c = obs_rsp_c; held_id = obs_rsp_id;
                check_eq("bp_valid", obs_rsp_valid, 1);
            end else begin
                check_eq("bp_c_stable", obs_rsp_c, held_c);
                check_eq("bp_id_stable", obs_rsp_id, held_id);
            end
            if (obs_req_ready[1]) dut_acc++;
            if (last_acc) begin mdl_acc++; new_data(1); end
        end
        check_eq("bp_accepts", dut_acc, mdl_acc);
        check_eq("bp_stalled", obs_req_ready, 0);
        rsp_ready = 1'b1;
        repeat (4) begin
            tick();
            if (last_acc) new_data(1);
        end
        req_valid = '0;
        repeat (3) tick();
        check_eq("bp_drained", busy, 0);

        // Random traffic with random backpressure and occasional withdrawn requests.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(2) == 0) begin
                    new_data(i);
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
            tick();
            if (last_acc) req_valid[last_acc_id] = 1'b0;
        end
        req_valid = '0; rsp_ready = 1'b1;
        repeat (3) tick();

        // Reset with both stages full.
        req_valid = '1; rsp_ready = 1'b0;
        repeat (3) begin
            tick();
            if (last_acc) new_data(last_acc_id);
        end
        check_eq("mid_full", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; rsp_ready = 1'b1; req_valid = '0;
        repeat (3) begin
            tick();
            check_eq("mid_no_rsp", obs_rsp_valid, 0);
        end
        check_eq("mid_busy", busy, 0);
        req_valid = '1;
        tick();
        check_eq("mid_rr_ptr", obs_req_ready, 4'b0001);
        req_valid = '0;
        repeat (3) tick();

        // Exhaustive operand sweep on requester 0.
        cnt0 = int'(op_count);
        done = 0; cyc = 0;
        req_valid = 4'b0001;
        while (done < 65536 && cyc < 90000) begin
            req_a[7:0] = 8'(done >> 8);
            req_b[7:0] = 8'(done);
            rsp_ready  = ($urandom_range(99) < 90);
            tick();
            cyc++;
            if (last_acc) done++;
        end
        check_eq("sweep_budget", done, 65536);
        req_valid = '0; rsp_ready = 1'b1;
        repeat (3) tick();
        check_eq("sweep_wrap", op_count, cnt0);
        check_eq("sweep_drained", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
